regfile_wrback: RTL
===================

REGFILE_WRBACK -- requirements
Module: regfile_wrback

Interface
REQ-001 Parameter FIFO_DEPTH, default 2: entries in the long-latency response buffer (power of two, 2..8).
REQ-002 Parameter STARVE_LIM, default 4: consecutive cycles a non-empty buffer may lose arbitration before a hold is raised.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 cpurst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 mem2wb_wr_reg / mem2wb_wr_regindex / mem2wb_wr_wdata  in  1/5/32  pipeline writeback; no backpressure, always accepted.
REQ-006 lsu_rsp_valid / lsu_rsp_regindex / lsu_rsp_wdata  in  1/5/32  long-latency (load/divide) response.
REQ-007 lsu_rsp_ready  out  1  response accepted when valid&ready on a rising edge.
REQ-008 issue_lng_valid / issue_lng_regindex  in  1/5  decode issued a long-latency op targeting that register.
REQ-009 rs1_addr / rs2_addr / rs3_addr  in  5 each  decode source queries.
REQ-010 rs1_busy / rs2_busy / rs3_busy  out  1 each  queried register awaits a long-latency result.
REQ-011 wb_hold  out  1  request upstream to bubble the pipeline writeback.
REQ-012 wb2regfile_wr_reg / wb2regfile_wr_regindex / wb2regfile_wr_wdata  out  1/5/32  registered regfile write port.

Function
REQ-013 Response buffer is a FIFO_DEPTH-entry FIFO of {regindex, wdata}; lsu_rsp_ready = !full, combinational from state only.
REQ-014 Push on lsu_rsp_valid&lsu_rsp_ready; responses with regindex 0 are accepted but never pushed.
REQ-015 Each cycle exactly one source is selected: mem2wb when mem2wb_wr_reg=1 and regindex!=0, else FIFO head when non-empty (pop), else none.
REQ-016 Selected source appears on wb2regfile_* the next cycle (latency 1); wb2regfile_wr_reg=0 when none selected; index/wdata hold last value when idle.
REQ-017 Simultaneous push and pop: both occur; pop of a full FIFO in the same cycle as a push is not allowed (ready already 0).
REQ-018 Push into empty FIFO is not poppable until the following cycle (no same-cycle bypass).
REQ-019 Starve counter (3 bits) increments when FIFO non-empty and mem2wb wins; clears on any pop or when FIFO empty.
REQ-020 wb_hold registered: set when starve counter reaches STARVE_LIM-1 and mem2wb wins again; cleared the cycle after a pop.
REQ-021 While wb_hold=1 upstream guarantees mem2wb_wr_reg=0; if violated, mem2wb still wins (no data loss) and counter saturates.
REQ-022 Scoreboard: 31-bit pending vector (x1..x31); set on issue_lng_valid with index!=0; cleared when that index is written to regfile from the FIFO.
REQ-023 Same-cycle set and clear of one index: set wins.
REQ-024 rsN_busy = pending[rsN_addr], combinational; always 0 for address 0.
REQ-025 Pipeline writes never clear pending bits; decode stalls on busy to prevent WAW.

Reset
REQ-026 On cpurst_n=0: FIFO empty, pointers 0, starve counter 0, pending all 0, wb_hold 0, wb2regfile_wr_reg 0, index 0, wdata 0.
REQ-027 Reset mid-operation discards buffered responses and pending bits; lsu_rsp_ready reads 1 in the first cycle after release.

Configuration
REQ-028 Macro WB_SCOREBOARD_EN defined: scoreboard per REQ-022..025 present.
REQ-029 WB_SCOREBOARD_EN undefined: no pending vector; rs1/2/3_busy tied 0; issue_lng_* ignored; all other behaviour unchanged.

Verification
REQ-030 mem2wb x5=0x1234 only -> next cycle wb2regfile_wr_reg=1, index 5, wdata 0x1234; one cycle later wr_reg=0.
REQ-031 lsu x7=0xAA and mem2wb x3=0x55 same cycle -> x3 written cycle+1, x7 written cycle+2, FIFO empty after.
REQ-032 Three lsu responses back-to-back with continuous mem2wb writes, FIFO_DEPTH=2 -> ready drops after two pushes; third held until a pop.
REQ-033 FIFO non-empty, mem2wb every cycle -> wb_hold=1 after 4 lost cycles; upstream bubbles; head popped; wb_hold=0 next cycle.
REQ-034 issue_lng x9, query rs2_addr=9 -> rs2_busy=1 until cycle after lsu x9 written; issue x9 on clear cycle -> busy stays 1.
REQ-035 Assert cpurst_n=0 with 2 buffered entries and pending x4 -> outputs zero immediately; after release no write occurs, rs busy=0.

Source files
------------

// File: rtl/regfile_wrback.sv
// regfile_wrback: register-file writeback arbiter; the pipeline write beats a long-latency response FIFO, with starvation hold.
// Optional busy scoreboard enabled by defining WB_SCOREBOARD_EN.
module regfile_wrback #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        cpurst_n,
  input  logic        mem2wb_wr_reg,
  input  logic [4:0]  mem2wb_wr_regindex,
  input  logic [31:0] mem2wb_wr_wdata,
  input  logic        lsu_rsp_valid,
  input  logic [4:0]  lsu_rsp_regindex,
  input  logic [31:0] lsu_rsp_wdata,
  output logic        lsu_rsp_ready,
  input  logic        issue_lng_valid,
  input  logic [4:0]  issue_lng_regindex,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rs3_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        rs3_busy,
  output logic        wb_hold,
  output logic        wb2regfile_wr_reg,
  output logic [4:0]  wb2regfile_wr_regindex,
  output logic [31:0] wb2regfile_wr_wdata
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [36:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [2:0]    starve;
  logic          empty, full, push, pop, sel_mem, fifo_wr;
  assign empty = count == '0;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign lsu_rsp_ready = !full;
  assign push = lsu_rsp_valid && !full && |lsu_rsp_regindex;
  assign sel_mem = mem2wb_wr_reg && |mem2wb_wr_regindex;
  assign pop = !sel_mem && !empty;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {lsu_rsp_regindex, lsu_rsp_wdata};
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      starve <= '0;
      wb_hold <= 1'b0;
      fifo_wr <= 1'b0;
      wb2regfile_wr_reg <= 1'b0;
      wb2regfile_wr_regindex <= '0;
      wb2regfile_wr_wdata <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      wb2regfile_wr_reg <= sel_mem || pop;
      fifo_wr <= pop;
      if (sel_mem) {wb2regfile_wr_regindex, wb2regfile_wr_wdata} <= {mem2wb_wr_regindex, mem2wb_wr_wdata};
      else if (pop) {wb2regfile_wr_regindex, wb2regfile_wr_wdata} <= mem[rd_ptr];
      // counter saturates if upstream ignores the hold
      if (empty || pop) starve <= '0;
      else if (sel_mem && starve != 3'd7) starve <= starve + 3'd1;
      if (pop) wb_hold <= 1'b0;
      else if (!empty && sel_mem && starve >= 3'(STARVE_LIM - 1)) wb_hold <= 1'b1;
    end
  end
`ifdef WB_SCOREBOARD_EN
  logic [31:0] pending, clr_mask, set_mask;
  // clear after the FIFO result reaches the regfile; a same-cycle issue re-sets the bit
  assign clr_mask = fifo_wr ? 32'd1 << wb2regfile_wr_regindex : '0;
  assign set_mask = issue_lng_valid ? 32'd1 << issue_lng_regindex : '0;
  always_ff @(posedge clk or negedge cpurst_n)
    if (!cpurst_n) pending <= '0;
    else pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
  assign rs1_busy = pending[rs1_addr];
  assign rs2_busy = pending[rs2_addr];
  assign rs3_busy = pending[rs3_addr];
`else
  logic unused_ok;
  assign unused_ok = ^{fifo_wr, issue_lng_valid, issue_lng_regindex, rs1_addr, rs2_addr, rs3_addr};
  assign rs1_busy = 1'b0;
  assign rs2_busy = 1'b0;
  assign rs3_busy = 1'b0;
`endif
endmodule
